// File: rtl/seg_execute_if.sv
// EX-stage bus: ID/EX operands and control in, EX/MEM register fields and stall out.
// The master side is the upstream pipeline; the slave side is seg_execute.
interface seg_execute_if #(
    parameter int LEN        = 32,
    parameter int NB_ADDR    = 5,
    parameter int NB_CTRL_WB = 2,
    parameter int NB_CTRL_M  = 3,
    parameter int NB_ALU_OP  = 4
);
    logic                  i_valid;
    logic                  i_flush;
    logic [LEN-1:0]        i_PC_next;
    logic [LEN-1:0]        i_imm;
    logic [LEN-1:0]        i_rs_data;
    logic [LEN-1:0]        i_rt_data;
    logic [NB_ADDR-1:0]    i_rt_addr;
    logic [NB_ADDR-1:0]    i_rd_addr;
    logic                  i_RegDst;
    logic                  i_ALUSrc;
    logic [NB_ALU_OP-1:0]  i_alu_op;
    logic [NB_CTRL_WB-1:0] i_ctrl_wb_bus;
    logic [NB_CTRL_M-1:0]  i_ctrl_mem_bus;

    logic                  o_stall;
    logic [LEN-1:0]        o_PC_branch;
    logic [LEN-1:0]        o_ALU_result;
    logic [LEN-1:0]        o_write_data;
    logic [NB_ADDR-1:0]    o_write_register;
    logic                  o_ALU_zero;
    logic [NB_CTRL_WB-1:0] o_ctrl_wb_bus;
    logic [NB_CTRL_M-1:0]  o_ctrl_mem_bus;

    modport master (
        output i_valid, i_flush, i_PC_next, i_imm, i_rs_data, i_rt_data,
               i_rt_addr, i_rd_addr, i_RegDst, i_ALUSrc, i_alu_op,
               i_ctrl_wb_bus, i_ctrl_mem_bus,
        input  o_stall, o_PC_branch, o_ALU_result, o_write_data,
               o_write_register, o_ALU_zero, o_ctrl_wb_bus, o_ctrl_mem_bus
    );

    modport slave (
        input  i_valid, i_flush, i_PC_next, i_imm, i_rs_data, i_rt_data,
               i_rt_addr, i_rd_addr, i_RegDst, i_ALUSrc, i_alu_op,
               i_ctrl_wb_bus, i_ctrl_mem_bus,
        output o_stall, o_PC_branch, o_ALU_result, o_write_data,
               o_write_register, o_ALU_zero, o_ctrl_wb_bus, o_ctrl_mem_bus
    );
endinterface

// File: rtl/seg_execute.sv
// MIPS execute stage: ALU, branch target, EX/MEM register and an iterative MULTU/DIVU unit.
// Define SEG_EXECUTE_DIV_EN to build the restoring divider; otherwise DIVU is a single-cycle no-op.
module seg_execute #(
    parameter int LEN        = 32,
    parameter int NB_ADDR    = 5,
    parameter int NB_CTRL_WB = 2,
    parameter int NB_CTRL_M  = 3,
    parameter int NB_ALU_OP  = 4
) (
    input  logic         i_clk,
    input  logic         i_rst,
    seg_execute_if.slave ex
);
    localparam int CNT_W = $clog2(LEN);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(LEN - 1);

    localparam logic [NB_ALU_OP-1:0] OP_ADD   = NB_ALU_OP'(0);
    localparam logic [NB_ALU_OP-1:0] OP_SUB   = NB_ALU_OP'(1);
    localparam logic [NB_ALU_OP-1:0] OP_AND   = NB_ALU_OP'(2);
    localparam logic [NB_ALU_OP-1:0] OP_OR    = NB_ALU_OP'(3);
    localparam logic [NB_ALU_OP-1:0] OP_XOR   = NB_ALU_OP'(4);
    localparam logic [NB_ALU_OP-1:0] OP_NOR   = NB_ALU_OP'(5);
    localparam logic [NB_ALU_OP-1:0] OP_SLT   = NB_ALU_OP'(6);
    localparam logic [NB_ALU_OP-1:0] OP_SLTU  = NB_ALU_OP'(7);
    localparam logic [NB_ALU_OP-1:0] OP_SLL   = NB_ALU_OP'(8);
    localparam logic [NB_ALU_OP-1:0] OP_SRL   = NB_ALU_OP'(9);
    localparam logic [NB_ALU_OP-1:0] OP_SRA   = NB_ALU_OP'(10);
    localparam logic [NB_ALU_OP-1:0] OP_LUI   = NB_ALU_OP'(11);
    localparam logic [NB_ALU_OP-1:0] OP_MULTU = NB_ALU_OP'(12);
    localparam logic [NB_ALU_OP-1:0] OP_DIVU  = NB_ALU_OP'(13);
    localparam logic [NB_ALU_OP-1:0] OP_MFHI  = NB_ALU_OP'(14);
    localparam logic [NB_ALU_OP-1:0] OP_MFLO  = NB_ALU_OP'(15);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} md_state_t;

    md_state_t            md_state;
    logic [CNT_W-1:0]     md_count;
    logic [2*LEN-1:0]     md_work;
    logic [LEN-1:0]       md_opnd;
    logic [LEN-1:0]       hi_reg;
    logic [LEN-1:0]       lo_reg;
    logic [LEN:0]         md_sum;
    logic [2*LEN-1:0]     md_next;
    logic [LEN-1:0]       op_b;
    logic [4:0]           shamt;
    logic [LEN-1:0]       alu_result;
    logic                 md_op;
`ifdef SEG_EXECUTE_DIV_EN
    logic                 md_is_div;
    logic [LEN:0]         md_diff;
`endif

    assign op_b  = ex.i_ALUSrc ? ex.i_imm : ex.i_rt_data;
    assign shamt = ex.i_imm[10:6];

`ifdef SEG_EXECUTE_DIV_EN
    assign md_op = (ex.i_alu_op == OP_MULTU) || (ex.i_alu_op == OP_DIVU);
`else
    assign md_op = (ex.i_alu_op == OP_MULTU);
`endif

    assign ex.o_stall = !i_rst &&
                        (((md_state == IDLE) && ex.i_valid && md_op) || (md_state == BUSY));

    always_comb begin
        alu_result = '0;
        case (ex.i_alu_op)
            OP_ADD:   alu_result = ex.i_rs_data + op_b;
            OP_SUB:   alu_result = ex.i_rs_data - op_b;
            OP_AND:   alu_result = ex.i_rs_data & op_b;
            OP_OR:    alu_result = ex.i_rs_data | op_b;
            OP_XOR:   alu_result = ex.i_rs_data ^ op_b;
            OP_NOR:   alu_result = ~(ex.i_rs_data | op_b);
            OP_SLT:   alu_result = {{(LEN-1){1'b0}}, $signed(ex.i_rs_data) < $signed(op_b)};
            OP_SLTU:  alu_result = {{(LEN-1){1'b0}}, ex.i_rs_data < op_b};
            OP_SLL:   alu_result = op_b << shamt;
            OP_SRL:   alu_result = op_b >> shamt;
            OP_SRA:   alu_result = $unsigned($signed(op_b) >>> shamt);
            OP_LUI:   alu_result = op_b << 16;
            // MULTU/DIVU only reach the EX/MEM capture in DONE, when LO already holds the result
            OP_MULTU: alu_result = lo_reg;
`ifdef SEG_EXECUTE_DIV_EN
            OP_DIVU:  alu_result = lo_reg;
`else
            OP_DIVU:  alu_result = '0;
`endif
            OP_MFHI:  alu_result = hi_reg;
            OP_MFLO:  alu_result = lo_reg;
            default:  alu_result = '0;
        endcase
    end

    // One iteration step; md_work is {HI-part, LO-part} for both multiply and divide.
    always_comb begin
        md_sum  = {1'b0, md_work[2*LEN-1:LEN]} + (md_work[0] ? {1'b0, md_opnd} : {(LEN+1){1'b0}});
        md_next = {md_sum, md_work[LEN-1:1]};
`ifdef SEG_EXECUTE_DIV_EN
        md_diff = md_work[2*LEN-1:LEN-1] - {1'b0, md_opnd};
        if (md_is_div) begin
            if (!md_diff[LEN]) begin
                md_next = {md_diff[LEN-1:0], md_work[LEN-2:0], 1'b1};
            end else begin
                md_next = {md_work[2*LEN-2:0], 1'b0};
            end
        end
`endif
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            md_state <= IDLE;
            md_count <= '0;
            md_work  <= '0;
            md_opnd  <= '0;
            hi_reg   <= '0;
            lo_reg   <= '0;
`ifdef SEG_EXECUTE_DIV_EN
            md_is_div <= 1'b0;
`endif
        end else begin
            case (md_state)
                IDLE: begin
                    if (ex.i_valid && md_op) begin
                        md_state <= BUSY;
                        md_count <= '0;
                        md_work  <= {{LEN{1'b0}}, ex.i_rs_data};
                        md_opnd  <= op_b;
`ifdef SEG_EXECUTE_DIV_EN
                        md_is_div <= (ex.i_alu_op == OP_DIVU);
`endif
                    end
                end
                BUSY: begin
                    if (ex.i_flush) begin
                        md_state <= IDLE;
                    end else begin
                        md_work  <= md_next;
                        md_count <= md_count + 1'b1;
                        if (md_count == LAST_STEP) begin
                            hi_reg   <= md_next[2*LEN-1:LEN];
                            lo_reg   <= md_next[LEN-1:0];
                            md_state <= DONE;
                        end
                    end
                end
                DONE:    md_state <= IDLE;
                default: md_state <= IDLE;
            endcase
        end
    end

    // EX/MEM register: killed or stalled slots become bubbles, data fields only move on a capture.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ex.o_PC_branch      <= '0;
            ex.o_ALU_result     <= '0;
            ex.o_write_data     <= '0;
            ex.o_write_register <= '0;
            ex.o_ALU_zero       <= 1'b0;
            ex.o_ctrl_wb_bus    <= '0;
            ex.o_ctrl_mem_bus   <= '0;
        end else if (ex.i_flush || !ex.i_valid || ex.o_stall) begin
            ex.o_ctrl_wb_bus  <= '0;
            ex.o_ctrl_mem_bus <= '0;
        end else begin
            ex.o_PC_branch      <= ex.i_PC_next + (ex.i_imm << 2);
            ex.o_ALU_result     <= alu_result;
            ex.o_ALU_zero       <= (alu_result == '0);
            ex.o_write_data     <= ex.i_rt_data;
            ex.o_write_register <= ex.i_RegDst ? ex.i_rd_addr : ex.i_rt_addr;
            ex.o_ctrl_wb_bus    <= ex.i_ctrl_wb_bus;
            ex.o_ctrl_mem_bus   <= ex.i_ctrl_mem_bus;
        end
    end
endmodule

// File: doc/seg_execute.md
# seg_execute

Execute stage of the 5-stage MIPS pipeline, directly upstream of `seg_memory_access`. It takes decoded operands and control from the ID/EX latch and computes the ALU result, zero flag, branch target and destination register. All of this is captured into an internal EX/MEM register whose outputs drive the memory-access stage. It also contains an iterative unsigned multiply/divide unit with HI/LO registers, which stalls the front of the pipeline while busy.

## Interface
- `LEN`, 32, datapath width
- `NB_ADDR`, 5, register-address width
- `NB_CTRL_WB`, 2, WB control bus width [RegWrite, MemtoReg]
- `NB_CTRL_M`, 3, MEM control bus width [Branch, MemRead, MemWrite]
- `NB_ALU_OP`, 4, ALU opcode width
- Clock and reset (already decided): one clock; reset is asynchronous and active-high.
  - `i_clk` in 1: clock
  - `i_rst` in 1: asynchronous, active-high reset
- `i_valid` in 1: ID/EX holds a real instruction
- `i_flush` in 1: kill current EX instruction
- `i_PC_next` in LEN: PC+4 of the instruction
- `i_imm` in LEN: sign-extended immediate; shamt = `i_imm[10:6]`
- `i_rs_data`, `i_rt_data` in LEN: register operands
- `i_rt_addr`, `i_rd_addr` in NB_ADDR: destination candidates
- `i_RegDst`, `i_ALUSrc` in 1: select rd / select imm as operand B
- `i_alu_op` in NB_ALU_OP: operation code
- `i_ctrl_wb_bus` in NB_CTRL_WB, `i_ctrl_mem_bus` in NB_CTRL_M: pass-through control
- `o_stall` out 1: hold PC, IF/ID and ID/EX
- `o_PC_branch`, `o_ALU_result`, `o_write_data` out LEN: registered EX/MEM fields
- `o_write_register` out NB_ADDR, `o_ALU_zero` out 1: registered
- `o_ctrl_wb_bus` out NB_CTRL_WB, `o_ctrl_mem_bus` out NB_CTRL_M: registered

## Operation
- B = `i_ALUSrc` ? `i_imm` : `i_rt_data`. Destination = `i_RegDst` ? rd : rt. `o_write_data` = `i_rt_data`.
- Branch target: `i_PC_next + (i_imm << 2)`, modulo 2^LEN. Zero flag: result == 0.
- Opcodes:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR
  - 6 SLT (signed), 7 SLTU
  - 8 SLL, 9 SRL, 10 SRA, each by shamt on B
  - 11 LUI = B<<16
  - 12 MULTU, 13 DIVU
  - 14 MFHI, 15 MFLO
- All add/sub wrap; no overflow trap.
- Mul/div FSM states are IDLE, BUSY and DONE.
  - IDLE→BUSY: when `i_valid` and op is 12/13. Latch rs/B and clear a 5-bit counter.
  - BUSY: one shift-add (MULTU) or restoring-subtract (DIVU) step per cycle. After step 31, write HI/LO and go to DONE.
  - DONE→IDLE: unconditional.
- `o_stall` = (IDLE & `i_valid` & op∈{12,13}) | BUSY.
- MULTU result: {HI,LO} = 64-bit product. DIVU result: LO = quotient, HI = remainder.
- DIVU by zero: LO = 0xFFFFFFFF, HI = dividend. No exception.
- EX/MEM register update priority:
  1. reset
  2. `i_flush` or !`i_valid`: ctrl buses ← 0
  3. `o_stall`: ctrl buses ← 0 (bubble)
  4. otherwise capture all fields
- In every case other than a full capture, the data fields hold.
- MULTU/DIVU retire in DONE with `o_ALU_result` = new LO and their own control buses (the decoder issues RegWrite=0).
- `i_flush` while BUSY: abort to IDLE and leave HI/LO unchanged.

## Timing
- Reset (asynchronous): all outputs 0, FSM in IDLE, HI = LO = 0, counter = 0.
- Single-cycle ops: result appears on outputs at the first rising edge after presentation.
- MULTU/DIVU:
  - C0 (acceptance): `o_stall`=1.
  - C1..C32: BUSY, `o_stall`=1.
  - End of C32: HI/LO written.
  - C33: DONE, `o_stall`=0, and EX/MEM captures the instruction at the end of this cycle.
  - Total: 33 stall cycles.
- MFHI/MFLO in the next instruction see the new values; no extra hazard logic.
- A flush asserted in BUSY drops `o_stall` in the following cycle.
- Upstream holds all inputs stable while `o_stall`=1.

## Configuration
- `SEG_EXECUTE_DIV_EN` defined: DIVU executes as described.
- `SEG_EXECUTE_DIV_EN` undefined:
  - No divider hardware is built.
  - Op 13 completes single-cycle with no stall, HI/LO unchanged and `o_ALU_result` = 0.
  - MULTU is unaffected.

## Test plan
- ADD, rs=5, B=7 → next edge: `o_ALU_result`=12, `o_ALU_zero`=0, ctrl buses equal to inputs.
- SUB as BEQ, rs=rt=0x10, `i_PC_next`=0x104, imm=3 → `o_ALU_zero`=1, `o_PC_branch`=0x110.
- MULTU 0xFFFFFFFF×2 → `o_stall` high exactly 33 cycles. Following MFHI gives 0x1; MFLO gives 0xFFFFFFFE.
- DIVU 100/7 → LO=14, HI=2. DIVU 9/0 → LO=0xFFFFFFFF, HI=9 (with the macro defined).
- `i_flush` on BUSY cycle 10 → `o_stall` low next cycle, EX/MEM ctrl buses 0, HI/LO keep prior values.
- `i_rst` pulsed mid-BUSY, away from a clock edge → all outputs 0 immediately, FSM in IDLE, `o_stall`=0.
